// File: rtl/tennis_referee_if.sv
// Court-side signal bundle for tennis_referee: the ball LED vector and all
// score/status outputs. master drives the ball, slave is the referee.
interface tennis_referee_if;
  logic [15:0] ball;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic [3:0]  pos;
  logic        pos_valid;
  logic        dir;
  logic        point_left;
  logic        point_right;
  logic        game_over;
  logic [1:0]  winner;
  logic        error;

  modport master (
    output ball,
    input  score_left, score_right, pos, pos_valid, dir,
    input  point_left, point_right, game_over, winner, error
  );

  modport slave (
    input  ball,
    output score_left, score_right, pos, pos_valid, dir,
    output point_left, point_right, game_over, winner, error
  );
endinterface

// File: rtl/tennis_referee.sv
// Pong-style tennis referee: tracks a one-hot ball across a 16-LED court,
// awards points on baseline misses and declares a winner at WIN_SCORE.
module tennis_referee #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input logic             clk,
  input logic             reset,
  tennis_referee_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRally = 2'd1;
  localparam logic [1:0] StPoint = 2'd2;
  localparam logic [1:0] StOver  = 2'd3;

  localparam logic [3:0]  WinScore = 4'(WIN_SCORE);
  localparam logic [31:0] HoldLast = 32'(HOLD_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [3:0]  score_left_q, score_left_d;
  logic [3:0]  score_right_q, score_right_d;
  logic [3:0]  pos_q, pos_d;
  logic        pos_valid_q, pos_valid_d;
  logic        dir_q, dir_d;
  logic        point_left_q, point_left_d;
  logic        point_right_q, point_right_d;
  logic        game_over_q, game_over_d;
  logic [1:0]  winner_q, winner_d;
  logic        error_q, error_d;

  logic        one_hot, multi;
  logic [3:0]  ball_idx;
  logic [3:0]  left_inc, right_inc;

  always_comb begin
    one_hot  = (bus.ball != 16'd0) && ((bus.ball & (bus.ball - 16'd1)) == 16'd0);
    multi    = (bus.ball != 16'd0) && !one_hot;
    ball_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (bus.ball[i]) ball_idx = 4'(i);
    end
    // Saturating increments so a score can never pass WIN_SCORE or wrap.
    left_inc  = (score_left_q < WinScore) ? score_left_q + 4'd1 : score_left_q;
    right_inc = (score_right_q < WinScore) ? score_right_q + 4'd1 : score_right_q;
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    pos_d         = pos_q;
    pos_valid_d   = one_hot;
    dir_d         = dir_q;
    point_left_d  = 1'b0;
    point_right_d = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;
    error_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (one_hot) begin
          pos_d   = ball_idx;
          state_d = StRally;
        end else if (multi) begin
          error_d = 1'b1;
        end
      end
      StRally: begin
        if (one_hot) begin
          pos_d = ball_idx;
          if (ball_idx != pos_q) dir_d = (ball_idx > pos_q);
        end else if (multi) begin
          error_d = 1'b1;
        end else if (pos_q == 4'd15) begin
          score_right_d = right_inc;
          point_right_d = 1'b1;
          hold_d        = 32'd0;
          state_d       = StPoint;
          if (right_inc == WinScore) begin
            game_over_d = 1'b1;
            winner_d    = 2'b10;
          end
        end else if (pos_q == 4'd0) begin
          score_left_d = left_inc;
          point_left_d = 1'b1;
          hold_d       = 32'd0;
          state_d      = StPoint;
          if (left_inc == WinScore) begin
            game_over_d = 1'b1;
            winner_d    = 2'b01;
          end
        end else begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StPoint: begin
        // The court is blanked while the point is displayed.
        pos_valid_d = 1'b0;
        if (hold_q == HoldLast) begin
          hold_d  = 32'd0;
          state_d = game_over_q ? StOver : StIdle;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        if (one_hot) pos_d = ball_idx;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      hold_q        <= 32'd0;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      pos_q         <= 4'd0;
      pos_valid_q   <= 1'b0;
      dir_q         <= 1'b0;
      point_left_q  <= 1'b0;
      point_right_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 2'b00;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      dir_q         <= dir_d;
      point_left_q  <= point_left_d;
      point_right_q <= point_right_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
      error_q       <= error_d;
    end
  end

  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.pos         = pos_q;
  assign bus.pos_valid   = pos_valid_q;
  assign bus.dir         = dir_q;
  assign bus.point_left  = point_left_q;
  assign bus.point_right = point_right_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_tennis_referee.sv
// Directed bench for tennis_referee with WIN_SCORE = 3 and HOLD_CYCLES = 4.
module tb_tennis_referee;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RALLY = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  tennis_referee_if bus ();

  tennis_referee #(
    .WIN_SCORE   (3),
    .HOLD_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Apply one ball sample and look at the registered response 1 after the edge.
  task automatic step(input logic [15:0] b);
    bus.ball = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(16'h0000);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0) begin bad++;
      $display("FAIL reset_scores got=%0d/%0d want=0/0", bus.score_left, bus.score_right); end
    total++; if (bus.pos !== 4'd0 || bus.pos_valid !== 1'b0 || bus.dir !== 1'b0) begin bad++;
      $display("FAIL reset_pos got=%0d/%b/%b want=0/0/0", bus.pos, bus.pos_valid, bus.dir); end
    total++; if (bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin bad++;
      $display("FAIL reset_game got=%b/%b want=0/00", bus.game_over, bus.winner); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++;
      $display("FAIL reset_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_rally();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(16'h0001 << i);
      total++; if (bus.pos !== 4'(i) || bus.pos_valid !== 1'b1) begin bad++;
        $display("FAIL rally_pos[%0d] got=%0d/%b want=%0d/1", i, bus.pos, bus.pos_valid, i); end
      total++; if (bus.dir !== (i > 0)) begin bad++;
        $display("FAIL rally_dir[%0d] got=%b want=%b", i, bus.dir, (i > 0)); end
      total++; if ({bus.point_left, bus.point_right, bus.error} !== 3'b000) begin bad++;
        $display("FAIL rally_pulses[%0d] got=%b want=000", i,
                 {bus.point_left, bus.point_right, bus.error}); end
    end
    total++; if (dut.state_q !== ST_RALLY) begin bad++;
      $display("FAIL rally_state got=%0d want=%0d", dut.state_q, ST_RALLY); end
  endtask

  // Continues from the rally: ball sits on bit 15.
  task automatic test_left_miss();
    step(16'h0000);
    total++; if (bus.point_right !== 1'b1 || bus.point_left !== 1'b0) begin bad++;
      $display("FAIL miss_pulse got=%b/%b want=1/0", bus.point_right, bus.point_left); end
    total++; if (bus.score_right !== 4'd1 || bus.score_left !== 4'd0) begin bad++;
      $display("FAIL miss_score got=%0d/%0d want=1/0", bus.score_right, bus.score_left); end
    total++; if (dut.state_q !== ST_POINT) begin bad++;
      $display("FAIL miss_state got=%0d want=%0d", dut.state_q, ST_POINT); end
    for (int c = 2; c <= 4; c++) begin
      step(16'h0101);
      total++; if (dut.state_q !== ST_POINT) begin bad++;
        $display("FAIL hold_state[%0d] got=%0d want=%0d", c, dut.state_q, ST_POINT); end
      total++; if ({bus.point_right, bus.error} !== 2'b00 || bus.score_right !== 4'd1) begin
        bad++; $display("FAIL hold_quiet[%0d] got=%b/%0d want=00/1", c,
                        {bus.point_right, bus.error}, bus.score_right); end
    end
    step(16'h0000);
    total++; if (dut.state_q !== ST_IDLE) begin bad++;
      $display("FAIL hold_exit got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic right_scores(input logic [3:0] want, input logic [1:0] end_state);
    step(16'h4000);
    step(16'h8000);
    step(16'h0000);
    total++; if (bus.point_right !== 1'b1 || bus.score_right !== want) begin bad++;
      $display("FAIL game_point got=%b/%0d want=1/%0d", bus.point_right, bus.score_right, want); end
    for (int c = 0; c < 4; c++) step(16'h0000);
    total++; if (dut.state_q !== end_state) begin bad++;
      $display("FAIL game_state got=%0d want=%0d", dut.state_q, end_state); end
  endtask

  // Continues from the left miss: score_right = 1.
  task automatic test_game();
    right_scores(4'd2, ST_IDLE);
    total++; if (bus.game_over !== 1'b0) begin bad++;
      $display("FAIL game_early got=%b want=0", bus.game_over); end
    right_scores(4'd3, ST_OVER);
    total++; if (bus.game_over !== 1'b1 || bus.winner !== 2'b10) begin bad++;
      $display("FAIL game_result got=%b/%b want=1/10", bus.game_over, bus.winner); end
    step(16'h0101);
    total++; if (bus.error !== 1'b0) begin bad++;
      $display("FAIL over_error got=%b want=0", bus.error); end
    step(16'h8000);
    step(16'h0000);
    total++; if ({bus.point_left, bus.point_right, bus.error} !== 3'b000) begin bad++;
      $display("FAIL over_pulses got=%b want=000", {bus.point_left, bus.point_right, bus.error}); end
    total++; if (bus.score_right !== 4'd3 || bus.score_left !== 4'd0 || bus.game_over !== 1'b1)
      begin bad++; $display("FAIL over_frozen got=%0d/%0d/%b want=3/0/1",
                            bus.score_right, bus.score_left, bus.game_over); end
  endtask

  task automatic test_illegal_and_right_miss();
    do_reset();
    step(16'h0010);
    step(16'h0020);
    step(16'h0101);
    total++; if (bus.error !== 1'b1 || bus.pos !== 4'd5 || bus.pos_valid !== 1'b0) begin bad++;
      $display("FAIL illegal got=%b/%0d/%b want=1/5/0", bus.error, bus.pos, bus.pos_valid); end
    total++; if (bus.dir !== 1'b1 || dut.state_q !== ST_RALLY || bus.score_left !== 4'd0) begin
      bad++; $display("FAIL illegal_hold got=%b/%0d/%0d want=1/%0d/0", bus.dir, dut.state_q,
                      bus.score_left, ST_RALLY); end
    step(16'h0040);
    total++; if (bus.error !== 1'b0 || bus.pos !== 4'd6) begin bad++;
      $display("FAIL illegal_after got=%b/%0d want=0/6", bus.error, bus.pos); end
    step(16'h0001);
    total++; if (bus.pos !== 4'd0 || bus.dir !== 1'b0) begin bad++;
      $display("FAIL rmiss_pos got=%0d/%b want=0/0", bus.pos, bus.dir); end
    step(16'h0000);
    total++; if (bus.point_left !== 1'b1 || bus.score_left !== 4'd1 || bus.score_right !== 4'd0)
      begin bad++; $display("FAIL rmiss got=%b/%0d/%0d want=1/1/0", bus.point_left,
                            bus.score_left, bus.score_right); end
  endtask

  task automatic test_vanish();
    do_reset();
    step(16'h0100);
    step(16'h0080);
    step(16'h0000);
    total++; if (bus.error !== 1'b1 || {bus.point_left, bus.point_right} !== 2'b00) begin bad++;
      $display("FAIL vanish got=%b/%b want=1/00", bus.error, {bus.point_left, bus.point_right}); end
    total++; if (dut.state_q !== ST_IDLE || bus.score_left !== 4'd0 || bus.score_right !== 4'd0)
      begin bad++; $display("FAIL vanish_state got=%0d/%0d/%0d want=%0d/0/0", dut.state_q,
                            bus.score_left, bus.score_right, ST_IDLE); end
    step(16'h0000);
    total++; if (bus.error !== 1'b0) begin bad++;
      $display("FAIL vanish_once got=%b want=0", bus.error); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(16'h8000);
    step(16'h0001);
    total++; if (bus.pos !== 4'd0 || bus.dir !== 1'b0 || {bus.point_left, bus.point_right} !== 2'b00)
      begin bad++; $display("FAIL wrap_right got=%0d/%b/%b want=0/0/00", bus.pos, bus.dir,
                            {bus.point_left, bus.point_right}); end
    step(16'h8000);
    total++; if (bus.pos !== 4'd15 || bus.dir !== 1'b1 || {bus.point_left, bus.point_right} !== 2'b00)
      begin bad++; $display("FAIL wrap_left got=%0d/%b/%b want=15/1/00", bus.pos, bus.dir,
                            {bus.point_left, bus.point_right}); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    step(16'h8000);
    step(16'h0000);
    step(16'h0000);
    total++; if (dut.state_q !== ST_POINT) begin bad++;
      $display("FAIL midhold_pre got=%0d want=%0d", dut.state_q, ST_POINT); end
    reset = 1'b1;
    step(16'h0000);
    reset = 1'b0;
    total++; if (dut.state_q !== ST_IDLE || dut.hold_q !== 32'd0) begin bad++;
      $display("FAIL midhold_state got=%0d/%0d want=%0d/0", dut.state_q, dut.hold_q, ST_IDLE); end
    total++; if (bus.score_right !== 4'd0 || bus.pos !== 4'd0 || bus.point_right !== 1'b0 ||
                 bus.game_over !== 1'b0 || bus.winner !== 2'b00) begin bad++;
      $display("FAIL midhold_outs got=%0d/%0d/%b/%b/%b want=0/0/0/0/00", bus.score_right,
               bus.pos, bus.point_right, bus.game_over, bus.winner); end
  endtask

  initial begin
    bus.ball = 16'h0000;
    test_reset();
    test_rally();
    test_left_miss();
    test_game();
    test_illegal_and_right_miss();
    test_vanish();
    test_wrap();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tennis_referee.md
TENNIS_REFEREE -- requirements
Module: tennis_referee

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a game; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 50_000_000: length of the point-display hold, in clk cycles; must be at least 1.
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ball  input  16  court LED vector; one-hot is a valid ball; bit 15 is the left baseline, bit 0 the right baseline; all-zero means no ball on court.
REQ-006 score_left  output  4  points won by the left player.
REQ-007 score_right  output  4  points won by the right player.
REQ-008 pos  output  4  index of the set bit of the last valid one-hot ball.
REQ-009 pos_valid  output  1  high while ball is currently one-hot.
REQ-010 dir  output  1  direction of travel; 1 = moving toward bit 15 (left), 0 = toward bit 0 (right).
REQ-011 point_left / point_right  output  1 each  one-cycle pulse when the named player is awarded a point.
REQ-012 game_over  output  1  high from the cycle the winning point is awarded.
REQ-013 winner  output  2  game result: 00 none, 01 left, 10 right.
REQ-014 error  output  1  one-cycle pulse on an illegal ball pattern.

Function
REQ-015 All outputs shall be registered; the response to a ball sample shall appear exactly 1 cycle later.
REQ-016 State machine states shall be IDLE, RALLY, POINT and OVER.
- IDLE -> RALLY on the first cycle ball is one-hot.
- RALLY -> POINT on a scored miss.
- RALLY -> IDLE on a mid-court vanish.
- POINT -> IDLE, or POINT -> OVER, after the hold.
- OVER is held until reset.
REQ-017 Position decode: ball one-hot -> pos = index of the set bit, pos_valid = 1; any other pattern -> pos holds its last value, pos_valid = 0.
REQ-018 Direction: in RALLY, when a new valid pos differs from the previous valid pos, dir shall become (new > old). dir shall hold when pos is unchanged.
REQ-019 Left miss: previous valid ball = bit 15 and current ball = 0, in RALLY.
- score_right shall increment by 1.
- point_right shall pulse for 1 cycle.
- State shall go to POINT.
REQ-020 Right miss: previous valid ball = bit 0 and current ball = 0, in RALLY.
- score_left shall increment by 1.
- point_left shall pulse for 1 cycle.
- State shall go to POINT.
REQ-021 Mid-court vanish: ball becomes 0 from any position 1..14 in RALLY -> error pulse, no score change, state to IDLE.
REQ-022 A ball with 2 or more bits set shall pulse error for 1 cycle in any state, with no state, score, pos or dir change.
REQ-023 POINT shall last exactly HOLD_CYCLES cycles.
- ball is ignored during POINT, including for error detection.
- On exit: if the awarded player's score = WIN_SCORE -> OVER, else -> IDLE.
REQ-024 On entry to OVER: game_over = 1 and winner = 01 or 10, both held until reset.
- Scores shall be frozen.
- No further point or error pulses.
REQ-025 Scores shall never exceed WIN_SCORE and shall never wrap.
REQ-026 A transition from bit 15 directly to bit 0 (or bit 0 directly to bit 15) shall be a legal move; it updates pos and dir and awards no point.
REQ-027 The point decision shall use only the previous valid pos and the current ball; pos_valid on the previous cycle is irrelevant.

Reset
REQ-028 Reset shall take priority over every other event, in any state including mid-hold.
REQ-029 On reset, in the same clock edge:
- state = IDLE
- scores = 0
- pos = 0, pos_valid = 0, dir = 0
- pulses = 0
- game_over = 0, winner = 00
- hold counter = 0

Verification (HOLD_CYCLES = 4, WIN_SCORE = 3)
REQ-030 Rally: ball walks bit 0 -> bit 15, one step per cycle -> pos tracks the ball 1 cycle late, dir = 1, no pulses.
REQ-031 Left miss: ball = 16'h8000, then 0 -> point_right pulses once, score_right = 1; POINT lasts 4 cycles; state returns to IDLE.
REQ-032 Game: right player scores 3 times -> game_over = 1, winner = 10; later ball activity produces no pulses.
REQ-033 Illegal ball 16'h0101 during RALLY -> single error pulse; pos and scores unchanged.
REQ-034 Mid-court vanish from bit 7 -> error pulse, no score change, state IDLE.
REQ-035 Reset asserted on the 2nd cycle of POINT -> next cycle all outputs at reset values, state IDLE.
